// File: rtl/accum_table_pkg.sv
// rtl/accum_table_pkg.sv - shared sizing and address map for the output accumulator table
package accum_table_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int MAX_OUT_ROWS = 128;
  localparam int MAX_OUT_COLS = 128;
  localparam int SYS_ARR_ROWS = 16;
  localparam int SYS_ARR_COLS = 16;

  localparam int NSM_M          = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NSM_N          = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * NSM_N;
  localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS);

  localparam int SM_M_W    = $clog2(NSM_M);
  localparam int SM_N_W    = $clog2(NSM_N);
  localparam int SUB_ROW_W = $clog2(SYS_ARR_ROWS);

  // Tile columns are stacked as full-height slabs; tile rows and sub-rows index within a slab.
  function automatic logic [ADDR_W-1:0] calc_addr(
    input logic [SM_M_W-1:0]    submat_m,
    input logic [SM_N_W-1:0]    submat_n,
    input logic [SUB_ROW_W-1:0] sub_row
  );
    logic [ADDR_W-1:0] addr;
    addr = ADDR_W'(submat_n) * ADDR_W'(MAX_OUT_ROWS)
         + ADDR_W'(submat_m) * ADDR_W'(SYS_ARR_ROWS)
         + ADDR_W'(sub_row);
    return addr;
  endfunction

endpackage

// File: rtl/accum_table_wr_skew.sv
// rtl/accum_table_wr_skew.sv - enable/address delay chain matching the array output skew
module accum_table_wr_skew
  import accum_table_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en_in,
  input  logic [ADDR_W-1:0]                  wr_addr,
  output logic [SYS_ARR_COLS-1:0]            wen,
  output logic [SYS_ARR_COLS-1:0][ADDR_W-1:0] waddr
);

  // Stage c feeds bank c, so bank c acts c+1 cycles after the row entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen   <= '0;
      waddr <= '0;
    end else begin
      wen[0]   <= wr_en_in;
      waddr[0] <= wr_addr;
      for (int i = 1; i < SYS_ARR_COLS; i++) begin
        wen[i]   <= wen[i-1];
        waddr[i] <= waddr[i-1];
      end
    end
  end

endmodule

// File: rtl/accum_table.sv
// rtl/accum_table.sv - per-column accumulating result banks with skewed writes and aligned reads
module accum_table
  import accum_table_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [SYS_ARR_COLS-1:0]              clear,
  input  logic                                 wr_en_in,
  input  logic [SM_M_W-1:0]                    wr_submat_m,
  input  logic [SM_N_W-1:0]                    wr_submat_n,
  input  logic [SUB_ROW_W-1:0]                 wr_sub_row,
  input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0]   wr_data,
  input  logic [SYS_ARR_COLS-1:0]              rd_en,
  input  logic [SM_M_W-1:0]                    rd_submat_m,
  input  logic [SM_N_W-1:0]                    rd_submat_n,
  input  logic [SUB_ROW_W-1:0]                 rd_sub_row,
  output logic [DATA_WIDTH*SYS_ARR_COLS-1:0]   rd_data
);

  logic [ADDR_W-1:0]                   wr_addr;
  logic [ADDR_W-1:0]                   rd_addr;
  logic [SYS_ARR_COLS-1:0]             wen;
  logic [SYS_ARR_COLS-1:0][ADDR_W-1:0] waddr;

  assign wr_addr = calc_addr(wr_submat_m, wr_submat_n, wr_sub_row);
  assign rd_addr = calc_addr(rd_submat_m, rd_submat_n, rd_sub_row);

  accum_table_wr_skew u_wr_skew (
    .clk      (clk),
    .reset    (reset),
    .wr_en_in (wr_en_in),
    .wr_addr  (wr_addr),
    .wen      (wen),
    .waddr    (waddr)
  );

  genvar c;
  generate
    for (c = 0; c < SYS_ARR_COLS; c++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [NUM_ACCUM_ROWS];
      logic [DATA_WIDTH-1:0] wr_slice;
      logic [DATA_WIDTH-1:0] rd_q;

      assign wr_slice = wr_data[c*DATA_WIDTH +: DATA_WIDTH];
      assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_q;

      // Bank clear wins over an accumulate landing on the same edge; contents survive reset.
      always_ff @(posedge clk) begin
        if (clear[c]) begin
          for (int i = 0; i < NUM_ACCUM_ROWS; i++) begin
            mem[i] <= '0;
          end
        end else if (wen[c]) begin
          mem[waddr[c]] <= mem[waddr[c]] + wr_slice;
        end
      end

      // Registered read sees the pre-edge entry even when that entry is written this edge.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_q <= '0;
        end else if (rd_en[c]) begin
          rd_q <= mem[rd_addr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_accum_table.sv
// tb/tb_accum_table.sv - scoreboard bench for accum_table
module tb_accum_table;
  import accum_table_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int NC = SYS_ARR_COLS;
  localparam int BW = DW * NC;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        clear;
  logic                 wr_en_in;
  logic [SM_M_W-1:0]    wr_submat_m;
  logic [SM_N_W-1:0]    wr_submat_n;
  logic [SUB_ROW_W-1:0] wr_sub_row;
  logic [BW-1:0]        wr_data;
  logic [NC-1:0]        rd_en;
  logic [SM_M_W-1:0]    rd_submat_m;
  logic [SM_N_W-1:0]    rd_submat_n;
  logic [SUB_ROW_W-1:0] rd_sub_row;
  logic [BW-1:0]        rd_data;

  always #5 clk = ~clk;

  accum_table dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_en_in    (wr_en_in),
    .wr_submat_m (wr_submat_m),
    .wr_submat_n (wr_submat_n),
    .wr_sub_row  (wr_sub_row),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_submat_m (rd_submat_m),
    .rd_submat_n (rd_submat_n),
    .rd_sub_row  (rd_sub_row),
    .rd_data     (rd_data)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] mm [NC][NUM_ACCUM_ROWS];
  logic          hist_en [4096];
  int            hist_addr [4096];
  int            ecnt = 0;
  int            valid_from = 0;
  logic [BW-1:0] last_exp;
  logic [BW-1:0] sb_q [$];

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int addr_of(input int m, input int n, input int r);
    return (n * MAX_OUT_ROWS + m * SYS_ARR_ROWS + r) % NUM_ACCUM_ROWS;
  endfunction

  // Model the coming edge from the driven inputs, take the edge, then score any read.
  task automatic cyc(input string tag);
    logic [BW-1:0] exp;
    int ra;
    int src;
    ra  = addr_of(int'(rd_submat_m), int'(rd_submat_n), int'(rd_sub_row));
    exp = last_exp;
    for (int c = 0; c < NC; c++)
      if (rd_en[c]) exp[c*DW +: DW] = mm[c][ra];
    if (rd_en != '0) begin
      sb_q.push_back(exp);
      last_exp = exp;
    end
    hist_en[ecnt]   = wr_en_in;
    hist_addr[ecnt] = addr_of(int'(wr_submat_m), int'(wr_submat_n), int'(wr_sub_row));
    for (int c = 0; c < NC; c++) begin
      src = ecnt - c - 1;
      if (clear[c]) begin
        for (int i = 0; i < NUM_ACCUM_ROWS; i++) mm[c][i] = '0;
      end else if (src >= valid_from && hist_en[src]) begin
        mm[c][hist_addr[src]] = mm[c][hist_addr[src]] + wr_data[c*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
    ecnt++;
    if (sb_q.size() > 0) check(tag, rd_data, sb_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    last_exp = '0;
    check("rst_rd_data", rd_data, '0);
    repeat (3) begin
      @(posedge clk);
      ecnt++;
    end
    #1;
    reset = 1'b1;
    valid_from = ecnt;
  endtask

  task automatic read_row(input int m, input int n, input int r, input logic [NC-1:0] mask,
                          input string tag);
    rd_submat_m = SM_M_W'(m);
    rd_submat_n = SM_N_W'(n);
    rd_sub_row  = SUB_ROW_W'(r);
    rd_en       = mask;
    cyc(tag);
    rd_en       = '0;
  endtask

  // 32 rows into one tile; slice c carries the value for the row that entered c+1 cycles ago.
  task automatic burst(input int m, input int n);
    int v;
    wr_submat_m = SM_M_W'(m);
    wr_submat_n = SM_N_W'(n);
    for (int k = 0; k < 32 + NC + 1; k++) begin
      wr_en_in   = (k < 32);
      wr_sub_row = SUB_ROW_W'(k % SYS_ARR_ROWS);
      for (int c = 0; c < NC; c++) begin
        v = k - 1 - c;
        v = ((v % 32) + 32) % 32;
        wr_data[c*DW +: DW] = DW'(v);
      end
      cyc("burst");
    end
    wr_en_in = 1'b0;
  endtask

  // One row with constant data; optional clear at step clr_at, read of the row at rd_at (-2: every step).
  task automatic pulse(input int m, input int n, input int r, input logic [DW-1:0] d,
                       input logic [NC-1:0] clr_mask, input int clr_at, input int rd_at,
                       input string tag);
    wr_submat_m = SM_M_W'(m);
    wr_submat_n = SM_N_W'(n);
    wr_sub_row  = SUB_ROW_W'(r);
    rd_submat_m = SM_M_W'(m);
    rd_submat_n = SM_N_W'(n);
    rd_sub_row  = SUB_ROW_W'(r);
    wr_data     = {NC{d}};
    for (int k = 0; k < NC + 2; k++) begin
      wr_en_in = (k == 0);
      clear    = (k == clr_at) ? clr_mask : '0;
      rd_en    = (rd_at == -2 || k == rd_at) ? '1 : '0;
      cyc(tag);
    end
    wr_en_in = 1'b0;
    clear    = '0;
    rd_en    = '0;
  endtask

  function automatic logic [BW-1:0] tile00_formula(input int r);
    logic [BW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = DW'(2 * r + 16);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = '0; wr_en_in = 1'b0; wr_data = '0; rd_en = '0;
    wr_submat_m = '0; wr_submat_n = '0; wr_sub_row = '0;
    rd_submat_m = '0; rd_submat_n = '0; rd_sub_row = '0;
    last_exp = '0;

    do_reset();
    clear = '1; cyc("init_clear"); clear = '0;

    burst(0, 0);
    for (int r = 0; r < SYS_ARR_ROWS; r++) begin
      read_row(0, 0, r, '1, "t00_rd");
      check("t00_formula", rd_data, tile00_formula(r));
    end

    burst(2, 3);
    for (int r = 0; r < SYS_ARR_ROWS; r++) read_row(2, 3, r, '1, "t23_rd");
    for (int r = 0; r < SYS_ARR_ROWS; r++) read_row(0, 0, r, '1, "t00_keep");

    read_row(0, 0, 0, 16'h00FF, "rd_en_lo");
    read_row(0, 0, 1, 16'hFF00, "rd_en_hi");

    pulse(0, 0, 5, 8'h01, '0, -1, -2, "skew_step");
    read_row(0, 0, 5, '1, "skew_final");

    pulse(0, 0, 6, 8'h05, '0, -1, 1, "rw_same_edge");
    read_row(0, 0, 6, '1, "rw_after");

    wr_submat_m = '0; wr_submat_n = '0; wr_sub_row = SUB_ROW_W'(7);
    wr_data = {NC{8'h01}};
    wr_en_in = 1'b1; cyc("rst_wr");
    wr_en_in = 1'b0;
    repeat (3) cyc("rst_wr");
    do_reset();
    read_row(0, 0, 7, '1, "rst_drop");

    clear = '1; cyc("clear_all"); clear = '0;
    for (int r = 0; r < SYS_ARR_ROWS; r++) begin
      read_row(0, 0, r, '1, "clr_t00");
      check("clr_t00_zero", rd_data, '0);
      read_row(2, 3, r, '1, "clr_t23");
    end

    pulse(1, 0, 0, 8'hFF, '0, -1, -1, "wrap_a");
    pulse(1, 0, 0, 8'h02, '0, -1, -1, "wrap_b");
    read_row(1, 0, 0, '1, "wrap_rd");
    check("wrap_const", rd_data, {NC{8'h01}});

    pulse(0, 0, 9, 8'h07, 16'h0008, 4, -1, "clr_beats_wr");
    read_row(0, 0, 9, '1, "clr_beats_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_table.md
# accum_table

Output accumulator storage of the systolic-array TPU. It holds a full MAX_OUT_ROWS x MAX_OUT_COLS result matrix as SYS_ARR_COLS independent column banks. Each bank receives one systolic-array column. It accumulates skewed partial sums written by the array and serves un-skewed row reads addressed by sub-matrix tile index and row-within-tile. It sits between the systolic array outputs and the activation/output stage.

## Interface
- DATA_WIDTH, 8: bits per element; accumulation wraps modulo 2^DATA_WIDTH.
- MAX_OUT_ROWS, 128: rows of the largest output matrix.
- MAX_OUT_COLS, 128: columns of the largest output matrix.
- SYS_ARR_ROWS, 16: rows per tile.
- SYS_ARR_COLS, 16: columns per tile, and the number of banks.
- Derived:
  - NUM_ACCUM_ROWS = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS) (1024)
  - ADDR_W = clog2(NUM_ACCUM_ROWS)
  - NSM_M = MAX_OUT_ROWS/SYS_ARR_ROWS
  - NSM_N = MAX_OUT_COLS/SYS_ARR_COLS
- Ports:
  - clk  in  1  single clock, rising edge.
  - reset  in  1  asynchronous, active-low; clears controller pipeline and rd_data, not table contents.
  - clear  in  SYS_ARR_COLS  bit c synchronously zeroes every entry of bank c.
  - wr_en_in  in  1  a row of array output starts entering this cycle.
  - wr_submat_m  in  clog2(NSM_M)  tile row index of the write.
  - wr_submat_n  in  clog2(NSM_N)  tile column index of the write.
  - wr_sub_row  in  clog2(SYS_ARR_ROWS)  row within the tile.
  - wr_data  in  DATA_WIDTH*SYS_ARR_COLS  slice c (bits c*DATA_WIDTH +: DATA_WIDTH) goes to bank c; already skewed by the array.
  - rd_en  in  SYS_ARR_COLS  per-bank read enable.
  - rd_submat_m  in  clog2(NSM_M)  tile row index of the read.
  - rd_submat_n  in  clog2(NSM_N)  tile column index of the read.
  - rd_sub_row  in  clog2(SYS_ARR_ROWS)  row within the tile.
  - rd_data  out  DATA_WIDTH*SYS_ARR_COLS  registered read data, slice c from bank c.

## Operation
- Address map, same for read and write: addr = submat_n*MAX_OUT_ROWS + submat_m*SYS_ARR_ROWS + sub_row. Width ADDR_W, zero-extended arithmetic.
- Write skew: wr_en_in and the computed address enter a shift chain.
  - Bank c sees enable wen[c] and address waddr[c] exactly c+1 cycles after the input cycle.
- Write: at a rising edge with wen[c]=1, mem_c[waddr[c]] <= mem_c[waddr[c]] + wr_data slice c, taken in that same cycle. Sum truncated to DATA_WIDTH.
- Read: the address is combinational from the rd_* inputs and shared by all banks. At a rising edge with rd_en[c]=1, rd_data slice c <= mem_c[raddr]. With rd_en[c]=0 the slice holds its value.
- Priority per bank, same edge:
  - clear[c] beats a write.
  - A read of an address being written or cleared returns the pre-edge value.
- Reset (low, any time, async):
  - wen chain cleared to 0, addresses cleared to 0, rd_data cleared to 0.
  - Writes in flight are dropped.
  - Memory contents are untouched.
- Indices out of range are not checked; wrap is modulo the field widths.

## Timing
- Write latency: input cycle t affects bank c at edge t+c+1. A row fully lands after SYS_ARR_COLS+1 edges.
- Back-to-back wr_en_in every cycle is supported with no bubbles. Each column pipeline stage is independent.
- Read latency: 1 cycle; rd_data is valid the cycle after rd_en.
- Read-after-write: a read of the same address must be issued at least one cycle after the bank's write edge.
- clear: effective at the next edge. Bank c reads 0 from the following edge.

## Structure
- Shared package holds: the default parameters, derived localparams (NUM_ACCUM_ROWS, ADDR_W, NSM_M, NSM_N), and an address-compute function shared by the read and write paths.
- One natural sub-module: accum_table_wr_skew, the enable/address shift chain (SYS_ARR_COLS stages).
- Banks are generate-loop arrays in the top level.

## Test plan
- Write tile (0,0), wr_sub_row=count%16, wr_en_in for 32 cycles. wr_data shifts in byte count%32 at slice 0 while older bytes move up. Expect bank c entry r to be the sum of both passes: with tile-0 reads, slice c = 2r+16 (r = 0..15).
- Write tile (m=2,n=3) for 32 cycles; bank c address = 416+r. Read tile (2,3) sub_row r -> same accumulated values, 1 cycle after rd_en=16'hFFFF. Tile (0,0) contents are unchanged.
- Skew check: single wr_en_in pulse at t with addr 5, all data 1 -> wen[c] high only at cycle t+c+1. Each bank's entry 5 increments by 1 exactly once.
- clear=16'hFFFF for 1 cycle, then read tiles (0,0) and (2,3) -> all rd_data 0. Assert reset low mid-write -> no further banks updated, rd_data=0.
- Accumulate 0xFF + 0x02 at one address -> reads 0x01 (wrap).
- Same-edge clear[3] and write to bank 3 -> entry reads 0. Same-edge read/write of one address -> returns the old value.
